ser_to_par: RTL
===============

Name: ser_to_par

Overview:
Serial-to-parallel receiver. It is the far end of the link driven by the team's parallel-to-serial transmitter. It samples SerIn on each SerClock rising edge while SerValidFlag is high and assembles WIDTH consecutive bits into a word. Each completed word is presented on BusOut with a ParValid/ParReady handshake. The output stage is double-buffered, so reception of the next word continues while the current word waits for the consumer.

Parameters:
WIDTH, 32, word length in bits (at least 2)
MSB_FIRST, 1, 1 = first received bit lands in BusOut[WIDTH-1]; 0 = first bit lands in BusOut[0]

Ports:
SerClock  in  1  single system clock; all logic on its rising edge
SerReset  in  1  reset, synchronous, active-high
SerIn  in  1  serial data bit
SerValidFlag  in  1  SerIn holds a valid bit this cycle; a word is WIDTH consecutive valid cycles
BusOut  out  WIDTH  assembled word, stable while ParValid=1
ParValid  out  1  BusOut holds an unconsumed word
ParReady  in  1  consumer accepts BusOut on an edge where ParValid=1 and ParReady=1
FrameError  out  1  one-cycle pulse: SerValidFlag dropped mid-word
Overrun  out  1  sticky: a completed word was dropped because the output stage was full

Behaviour:
- Reset: SerReset=1 at a rising edge clears everything.
  - Outputs: BusOut=0, ParValid=0, FrameError=0, Overrun=0.
  - Internal: shift register=0, bit counter=0, state=IDLE.
  - Reset has priority over every other event.
  - Reset mid-word discards the partial word and any pending output word.
- Receive FSM states: IDLE (counter=0) and SHIFT (1 <= counter <= WIDTH-1).
  - IDLE, SerValidFlag=1: capture bit, counter=1, go to SHIFT.
  - IDLE, SerValidFlag=0: stay in IDLE.
  - SHIFT, SerValidFlag=1, counter<WIDTH-1: capture bit, counter+1.
  - SHIFT, SerValidFlag=1, counter=WIDTH-1: capture last bit, word complete, counter wraps to 0, go to IDLE.
  - SHIFT, SerValidFlag=0: discard partial word, counter=0, go to IDLE, FrameError=1 for exactly one cycle.
- Bit order:
  - MSB_FIRST=1: shift left, inserting SerIn at bit 0, so bit k of the stream ends at index WIDTH-1-k.
  - MSB_FIRST=0: shift right, inserting at bit WIDTH-1, so bit k ends at index k.
- Latency: on the edge that samples the last bit, the word loads into BusOut and ParValid is set. Both are visible in the cycle after the last bit is sampled.
- Output handshake, evaluated on each rising edge:
  - ParValid=1, ParReady=1, no completion: ParValid goes to 0; BusOut holds its value.
  - Completion with ParValid=0: load BusOut, ParValid=1.
  - Completion with ParValid=1 and ParReady=1 (same edge): old word transfers, new word loads, ParValid stays 1, no overrun.
  - Completion with ParValid=1 and ParReady=0: new word dropped, BusOut unchanged, Overrun set to 1.
  - Overrun is cleared only by SerReset.
- Back-to-back words: SerValidFlag held high for N*WIDTH cycles produces N words with no gap cycle. The counter wraps directly from word to word.
- ParReady while ParValid=0 is ignored.
- SerIn is ignored when SerValidFlag=0.
- FrameError and a completion cannot coincide. A SerValidFlag drop while in IDLE is not an error.

Test Plan:
1. Basic word: WIDTH=32, MSB_FIRST=1, ParReady=1; drive 0x1111_6666 MSB first with SerValidFlag high for 32 cycles -> ParValid=1 exactly one cycle after bit 31, BusOut=0x11116666; ParValid=0 on the following edge.
2. Back-to-back: stream 0xDEADBEEF then 0x12345678 contiguously (64 valid cycles), ParReady=1 -> two single-cycle ParValid pulses 32 cycles apart with BusOut=0xDEADBEEF then 0x12345678; FrameError=0 and Overrun=0 throughout.
3. Backpressure/overrun: ParReady=0; send 0xA5A5A5A5 then 0x0F0F0F0F -> BusOut stays 0xA5A5A5A5, ParValid=1, Overrun=1 after the second word. Then raise ParReady -> ParValid=0, Overrun stays 1 until SerReset.
4. Simultaneous accept and complete: hold word 0x00000001 pending with ParReady=0; raise ParReady on the exact edge the next word 0xFFFFFFFF completes -> BusOut=0xFFFFFFFF, ParValid=1, Overrun=0.
5. Frame abort: drop SerValidFlag after 10 bits, then send full 0xCAFEF00D -> FrameError pulses for one cycle, no ParValid for the partial word, next BusOut=0xCAFEF00D.
6. LSB-first and reset: with MSB_FIRST=0, send 0x1111_6666 LSB first -> BusOut=0x11116666. Then assert SerReset at bit 20 of the next word -> all outputs 0; the next full word is received correctly.

Source files
------------

// File: rtl/ser_to_par.sv
`default_nettype none
// ============================================================================
// Module   : ser_to_par
// Purpose  : Serial-to-parallel receiver with double-buffered valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module ser_to_par #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             SerClock,
  input  logic             SerReset,
  input  logic             SerIn,
  input  logic             SerValidFlag,
  output logic [WIDTH-1:0] BusOut,
  output logic             ParValid,
  input  logic             ParReady,
  output logic             FrameError,
  output logic             Overrun
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_nextCount;
  logic [WIDTH-1:0]   r_shiftReg;
  logic [WIDTH-1:0]   w_nextShift;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_complete;
  logic               w_frameErr;
  logic [WIDTH-1:0]   r_busOut;
  logic               r_parValid;
  logic               r_frameError;
  logic               r_overrun;

  // Bit order only changes which end of the shift register the new bit enters.
  if (MSB_FIRST) begin : g_msbFirst
    assign w_shifted = {r_shiftReg[WIDTH-2:0], SerIn};
  end else begin : g_lsbFirst
    assign w_shifted = {SerIn, r_shiftReg[WIDTH-1:1]};
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextShift = r_shiftReg;
    w_complete  = 1'b0;
    w_frameErr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (SerValidFlag) begin
          w_nextShift = w_shifted;
          w_nextCount = c_ONE;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (SerValidFlag) begin
          if (r_count == c_LAST) begin
            // Completed word leaves via w_shifted; register restarts clean.
            w_complete  = 1'b1;
            w_nextShift = '0;
            w_nextCount = '0;
            w_nextState = IDLE;
          end else begin
            w_nextShift = w_shifted;
            w_nextCount = r_count + c_ONE;
          end
        end else begin
          w_frameErr  = 1'b1;
          w_nextShift = '0;
          w_nextCount = '0;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge SerClock) begin
    if (SerReset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_shiftReg <= '0;
    end else begin
      r_state    <= w_nextState;
      r_count    <= w_nextCount;
      r_shiftReg <= w_nextShift;
    end
  end

  // Output stage: a completion may load in the same edge the old word is taken.
  always_ff @(posedge SerClock) begin
    if (SerReset) begin
      r_busOut     <= '0;
      r_parValid   <= 1'b0;
      r_frameError <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frameError <= w_frameErr;
      if (w_complete) begin
        if (!r_parValid || ParReady) begin
          r_busOut   <= w_shifted;
          r_parValid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_parValid && ParReady) begin
        r_parValid <= 1'b0;
      end
    end
  end

  assign BusOut     = r_busOut;
  assign ParValid   = r_parValid;
  assign FrameError = r_frameError;
  assign Overrun    = r_overrun;

endmodule
`default_nettype wire
